// File: rtl/irq_aggregator.sv
// -----------------------------------------------------------------------------
// irq_aggregator
//
// Collects up to NUM_SRC interrupt lines from timers and other peripherals into
// a pending register. Each source can be edge- or level-sensitive and has its
// own mask bit. The block drives one combined irq to the processor, plus the
// index of the lowest-numbered active source. Software controls it through a
// small 16-bit Avalon-MM slave with registered (1-cycle) reads.
//
// Register map (word address):
//   0 PENDING  R: pending            W: write-1-to-clear, edge-mode bits only
//   1 MASK     R/W per-source enable
//   2 MODE     R/W per-source mode, 1 = edge, 0 = level
//   3 ACTIVE   R: pending & mask     W: ignored
//   4 VECTOR   R: {valid, 11'b0, id} W: ignored
//   5 SWSET    W: write-1-to-set, edge-mode bits only   R: 0
//   6,7        R: 0                  W: ignored
// Register bits at or above NUM_SRC read as 0, and writes to them are dropped.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     Avalon-MM word address (3 bits)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   16-bit write data
//   readdata    16-bit registered read data, updated every cycle
//   irq_in      per-source interrupt lines, already synchronous to clk
//   irq         registered combined interrupt request
//   irq_id      registered index of the highest-priority active source
// -----------------------------------------------------------------------------
module irq_aggregator #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq,
  output logic [3:0]         irq_id
);

  localparam int PAD = 16 - NUM_SRC;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] irq_s_q,    irq_s_d;
  logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_SRC-1:0] pending_q,  pending_d;
  logic [NUM_SRC-1:0] mask_q,     mask_d;
  logic [NUM_SRC-1:0] mode_q,     mode_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q,      irq_d;
  logic [3:0]         irq_id_q,   irq_id_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic               wr_en;
  logic               wr_pending;
  logic               wr_mask;
  logic               wr_mode;
  logic               wr_swset;
  logic [NUM_SRC-1:0] wdata_src;
  logic               unused_wdata_bits;

  assign wr_en      = chipselect & ~write_n;
  assign wr_pending = wr_en && (address == ADDR_PENDING);
  assign wr_mask    = wr_en && (address == ADDR_MASK);
  assign wr_mode    = wr_en && (address == ADDR_MODE);
  assign wr_swset   = wr_en && (address == ADDR_SWSET);

  // Only the low NUM_SRC data bits map onto real sources.
  assign wdata_src         = writedata[NUM_SRC-1:0];
  assign unused_wdata_bits = ^writedata[15:NUM_SRC];

  // ---------------------------------------------------------------------------
  // Per-source event terms
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] rise_det;
  logic [NUM_SRC-1:0] w1c_bits;
  logic [NUM_SRC-1:0] swset_bits;
  logic [NUM_SRC-1:0] mode_chg;
  logic [NUM_SRC-1:0] active;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    // Rising edge seen between the two synchroniser-side samples.
    assign rise_det[gi]   = irq_s_q[gi] & ~irq_prev_q[gi];
    assign w1c_bits[gi]   = wr_pending & wdata_src[gi];
    assign swset_bits[gi] = wr_swset   & wdata_src[gi];
    // A source whose mode flips loses whatever it had pending, so a stale
    // level-captured bit can never masquerade as an edge event (or vice versa).
    assign mode_chg[gi]   = wr_mode & (wdata_src[gi] ^ mode_q[gi]);
    assign active[gi]     = pending_q[gi] & mask_q[gi];
  end

  // ---------------------------------------------------------------------------
  // Priority encoder: lowest index wins, 0 when nothing is active.
  // ---------------------------------------------------------------------------
  logic       active_any;
  logic [3:0] active_id;

  assign active_any = |active;

  always_comb begin
    active_id = 4'd0;
    // Scan from the top so the last hit (lowest index) is what remains.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        active_id = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Zero-extension of a per-source vector onto the 16-bit bus.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
    return {{PAD{1'b0}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Input stage: two samples kept back to back for edge detection.
    irq_s_d    = irq_in;
    irq_prev_d = irq_s_q;

    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_mask) begin
      mask_d = wdata_src;
    end
    if (wr_mode) begin
      mode_d = wdata_src;
    end

    // Pending update. The rule applied is the mode in force this cycle. A
    // mode change overrides everything for that bit in this cycle.
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pending_d[i] = irq_s_q[i];
      end else if (rise_det[i] || swset_bits[i]) begin
        // Set beats a simultaneous write-1-to-clear.
        pending_d[i] = 1'b1;
      end else if (w1c_bits[i]) begin
        pending_d[i] = 1'b0;
      end
    end

    // Outputs are derived from the current (pre-update) pending and mask, so
    // they lag a pending change by one cycle.
    irq_d    = active_any;
    irq_id_d = active_id;

    // Read mux: always sampled, and it reflects state before any same-cycle write.
    readdata_d = 16'h0000;
    case (address)
      ADDR_PENDING: readdata_d = zext(pending_q);
      ADDR_MASK:    readdata_d = zext(mask_q);
      ADDR_MODE:    readdata_d = zext(mode_q);
      ADDR_ACTIVE:  readdata_d = zext(active);
      ADDR_VECTOR:  readdata_d = {active_any, 11'b0, active_id};
      default:      readdata_d = 16'h0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_s_q    <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      readdata_q <= 16'h0000;
      irq_q      <= 1'b0;
      irq_id_q   <= 4'd0;
    end else begin
      irq_s_q    <= irq_s_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// -----------------------------------------------------------------------------
// tb_irq_aggregator
//
// Self-checking bench for irq_aggregator (NUM_SRC = 8). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point, after the
// following rising edge. A behavioural model keeps per-source state in
// integer arrays and applies the register rules on every edge. It stays in
// step with every applied cycle. The table and hand-written sequences check
// against fixed expected values. The random phase checks against the model.
// -----------------------------------------------------------------------------
module tb_irq_aggregator;

  localparam int NUM = 8;

  logic           clk;
  logic           reset_n;
  logic [2:0]     address;
  logic           chipselect;
  logic           write_n;
  logic [15:0]    writedata;
  logic [15:0]    readdata;
  logic [NUM-1:0] irq_in;
  logic           irq;
  logic [3:0]     irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  irq_aggregator #(.NUM_SRC(NUM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_pend [NUM];
  int          m_mask [NUM];
  int          m_mode [NUM];
  int          m_s    [NUM];
  int          m_prev [NUM];
  logic [15:0] m_rd;
  logic        m_irq;
  logic [3:0]  m_id;

  function automatic void model_step(input logic rn, input logic [2:0] a,
                                     input logic c, input logic wn,
                                     input logic [15:0] wd, input logic [NUM-1:0] ii);
    int          np [NUM];
    int          low;
    logic        wr;
    logic [15:0] rv;
    if (!rn) begin
      for (int i = 0; i < NUM; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0; m_s[i] = 0; m_prev[i] = 0;
      end
      m_rd = 16'h0; m_irq = 1'b0; m_id = 4'd0;
      return;
    end
    wr  = c & ~wn;
    low = -1;
    for (int i = NUM - 1; i >= 0; i--)
      if (m_pend[i] != 0 && m_mask[i] != 0) low = i;
    rv = 16'h0;
    for (int i = 0; i < NUM; i++) begin
      case (a)
        3'd0: rv[i] = (m_pend[i] != 0);
        3'd1: rv[i] = (m_mask[i] != 0);
        3'd2: rv[i] = (m_mode[i] != 0);
        3'd3: rv[i] = (m_pend[i] != 0) && (m_mask[i] != 0);
        default: rv[i] = 1'b0;
      endcase
    end
    if (a == 3'd4 && low >= 0) rv = 16'h8000 | 16'(low);
    m_rd  = rv;
    m_irq = (low >= 0);
    m_id  = (low >= 0) ? 4'(low) : 4'd0;
    for (int i = 0; i < NUM; i++) begin
      if (wr && a == 3'd2 && int'(wd[i]) != m_mode[i])           np[i] = 0;
      else if (m_mode[i] == 0)                                    np[i] = m_s[i];
      else if ((m_s[i] == 1 && m_prev[i] == 0) || (wr && a == 3'd5 && wd[i])) np[i] = 1;
      else if (wr && a == 3'd0 && wd[i])                          np[i] = 0;
      else                                                        np[i] = m_pend[i];
    end
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = np[i];
      if (wr && a == 3'd1) m_mask[i] = int'(wd[i]);
      if (wr && a == 3'd2) m_mode[i] = int'(wd[i]);
      m_prev[i] = m_s[i];
      m_s[i]    = int'(ii[i]);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic [2:0] a, input logic c,
                      input logic wn, input logic [15:0] wd, input logic [NUM-1:0] ii);
    reset_n    = rn;
    address    = a;
    chipselect = c;
    write_n    = wn;
    writedata  = wd;
    irq_in     = ii;
    @(posedge clk);
    model_step(rn, a, c, wn, wd, ii);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d, input logic [NUM-1:0] ii);
    step(1'b1, a, 1'b1, 1'b0, d, ii);
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [NUM-1:0] ii);
    step(1'b1, a, 1'b1, 1'b1, 16'h0000, ii);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           rn;
    logic [2:0]     a;
    logic           c;
    logic           wn;
    logic [15:0]    wd;
    logic [NUM-1:0] ii;
    logic [15:0]    exp_rd;
    logic           exp_irq;
    logic [3:0]     exp_id;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [NUM-1:0] irq_r;
    vec_t           v;

    // Reset, then read every address.
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 16'h0, 8'h00, 16'h0, 1'b0, 4'd0});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 16'h0, 8'h00, 16'h0, 1'b0, 4'd0});
    for (int a = 0; a < 8; a++)
      tbl.push_back('{1'b1, 3'(a), 1'b1, 1'b1, 16'h0, 8'h00, 16'h0, 1'b0, 4'd0});
    // Edge source 0: configure, one-cycle pulse, then write-1-to-clear.
    tbl.push_back('{1'b1, 3'd2, 1'b1, 1'b0, 16'h0001, 8'h00, 16'h0000, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 16'h0001, 8'h00, 16'h0000, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 16'h0000, 8'h01, 16'h0000, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 16'h0000, 8'h00, 16'h0001, 1'b1, 4'd0});
    tbl.push_back('{1'b1, 3'd0, 1'b1, 1'b0, 16'h0001, 8'h00, 16'h0001, 1'b1, 4'd0});
    tbl.push_back('{1'b1, 3'd0, 1'b1, 1'b1, 16'h0000, 8'h00, 16'h0000, 1'b0, 4'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.rn, v.a, v.c, v.wn, v.wd, v.ii);
      check($sformatf("vec%0d_rd", i),  readdata,     v.exp_rd);
      check($sformatf("vec%0d_irq", i), 16'(irq),     16'(v.exp_irq));
      check($sformatf("vec%0d_id", i),  16'(irq_id),  16'(v.exp_id));
      $display("vec %0d: addr=%0d wr=%0b wd=%04h irq_in=%02h -> rd=%04h irq=%0b id=%0d",
               i, v.a, v.c & ~v.wn, v.wd, v.ii, readdata, irq, irq_id);
    end

    // Level sources 3 and 5: priority and vector, W1C has no effect.
    wr_reg(3'd2, 16'h0000, 8'h00);
    wr_reg(3'd1, 16'h00FF, 8'h00);
    rd_reg(3'd4, 8'h28);
    rd_reg(3'd4, 8'h28);
    rd_reg(3'd4, 8'h28);
    check("lvl_vec_3", readdata, 16'h8003);
    check("lvl_id_3",  16'(irq_id), 16'd3);
    check("lvl_irq_3", 16'(irq), 16'd1);
    $display("seq level35: vector=%04h irq_id=%0d", readdata, irq_id);
    rd_reg(3'd4, 8'h20);
    rd_reg(3'd4, 8'h20);
    rd_reg(3'd4, 8'h20);
    check("lvl_vec_5", readdata, 16'h8005);
    check("lvl_id_5",  16'(irq_id), 16'd5);
    $display("seq level5: vector=%04h irq_id=%0d", readdata, irq_id);
    wr_reg(3'd0, 16'h0020, 8'h20);
    rd_reg(3'd0, 8'h20);
    check("lvl_w1c_ignored", readdata, 16'h0020);
    $display("seq level w1c: pending=%04h", readdata);
    for (int i = 0; i < 4; i++) rd_reg(3'd0, 8'h00);
    check("lvl_quiet_irq", 16'(irq), 16'd0);
    check("lvl_quiet_pend", readdata, 16'h0000);

    // Edge bits 1 and 2: set beats clear, SWSET, masked bit excluded from ACTIVE.
    wr_reg(3'd2, 16'h0006, 8'h00);
    wr_reg(3'd1, 16'h00FD, 8'h00);
    rd_reg(3'd0, 8'h04);
    wr_reg(3'd0, 16'h0004, 8'h04);
    rd_reg(3'd0, 8'h04);
    check("edge_set_wins", readdata, 16'h0004);
    $display("seq set-vs-clear: pending=%04h", readdata);
    wr_reg(3'd5, 16'h0002, 8'h04);
    rd_reg(3'd0, 8'h04);
    check("swset_pend", readdata, 16'h0006);
    rd_reg(3'd3, 8'h04);
    check("swset_active", readdata, 16'h0004);
    check("swset_id", 16'(irq_id), 16'd2);
    $display("seq swset: active=%04h irq_id=%0d", readdata, irq_id);
    wr_reg(3'd0, 16'h0006, 8'h04);
    rd_reg(3'd0, 8'h04);
    check("edge_w1c", readdata, 16'h0000);

    // Source 4: level to edge switch clears pending; a fresh edge re-sets it.
    rd_reg(3'd0, 8'h10);
    rd_reg(3'd0, 8'h10);
    rd_reg(3'd0, 8'h10);
    check("mode_lvl_pend", readdata, 16'h0010);
    wr_reg(3'd2, 16'h0016, 8'h10);
    rd_reg(3'd0, 8'h10);
    check("mode_chg_clr", readdata, 16'h0000);
    rd_reg(3'd0, 8'h10);
    check("mode_chg_hold", readdata, 16'h0000);
    rd_reg(3'd0, 8'h00);
    rd_reg(3'd0, 8'h10);
    rd_reg(3'd0, 8'h10);
    rd_reg(3'd0, 8'h10);
    check("mode_new_edge", readdata, 16'h0010);
    $display("seq mode switch: pending=%04h", readdata);

    // Mid-operation reset with everything pending; source 4 stays high.
    wr_reg(3'd2, 16'h00FF, 8'h10);
    wr_reg(3'd1, 16'h00FF, 8'h10);
    wr_reg(3'd5, 16'h00FF, 8'h10);
    rd_reg(3'd0, 8'h10);
    check("pre_rst_pend", readdata, 16'h00FF);
    check("pre_rst_irq", 16'(irq), 16'd1);
    step(1'b0, 3'd0, 1'b1, 1'b1, 16'h0000, 8'h10);
    check("rst_rd",  readdata, 16'h0000);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_id",  16'(irq_id), 16'd0);
    rd_reg(3'd0, 8'h10);
    check("rst_pend", readdata, 16'h0000);
    rd_reg(3'd1, 8'h10);
    check("rst_mask", readdata, 16'h0000);
    rd_reg(3'd2, 8'h10);
    check("rst_mode", readdata, 16'h0000);
    rd_reg(3'd0, 8'h10);
    check("post_rst_level_pend", readdata, 16'h0010);
    $display("seq reset: pending after release=%04h", readdata);

    // Random phase against the model.
    irq_r = 8'h10;
    for (int n = 0; n < 1500; n++) begin
      logic           rn, c, wn;
      logic [2:0]     a;
      logic [15:0]    wd;
      rn    = ($urandom_range(0, 99) != 0);
      a     = 3'($urandom_range(0, 7));
      c     = ($urandom_range(0, 3) != 0);
      wn    = 1'($urandom_range(0, 1));
      wd    = 16'($urandom);
      irq_r = irq_r ^ 8'($urandom & $urandom & $urandom);
      step(rn, a, c, wn, wd, irq_r);
      check($sformatf("rand%0d_rd", n),  readdata,    m_rd);
      check($sformatf("rand%0d_irq", n), 16'(irq),    16'(m_irq));
      check($sformatf("rand%0d_id", n),  16'(irq_id), 16'(m_id));
      $display("rand %0d: rst_n=%0b addr=%0d wr=%0b wd=%04h irq_in=%02h -> rd=%04h irq=%0b id=%0d",
               n, rn, a, c & ~wn, wd, irq_r, readdata, irq, irq_id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
